// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for uart_core.
//   uart_state_e : frame state used by both the transmitter and the receiver.
//                  ST_PARITY exists only when UART_PARITY_EN is defined.
//   maj3         : 2-of-3 majority vote used by the receiver sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } uart_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable oversample tick generator.
//   clk, rst  : clock, asynchronous active-high reset
//   baud_div  : clocks per tick; 0 behaves as 1
//   tick      : registered one-clock pulse, once every baud_div clocks
// The divisor is latched at each wrap, so a new baud_div applies from the
// following period and never truncates the one in progress.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             wrap;

    always_comb begin
        wrap   = (cnt_q == div_q - 1'b1);
        cnt_d  = wrap ? '0 : cnt_q + 1'b1;
        div_d  = div_q;
        if (wrap) begin
            div_d = (baud_div == '0) ? DIV_W'(1) : baud_div;
        end
        tick_d = wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= DIV_W'(1);
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_core.sv
// uart_core: single-clock UART transceiver with internal baud generator,
// 3-sample majority-vote receiver and double-buffered transmitter.
// Optional feature macro: UART_PARITY_EN (adds parity bit, Parity_Odd input
// and Rx_Parity_Err output).
//   Clock/Reset            : system clock, asynchronous active-high reset
//   Baud_Div               : clocks per oversample tick
//   Tx_Data/ld_Tx_Data     : load holding register
//   Tx_Enable              : permit a new frame to start
//   Tx_Out/Tx_Empty/Tx_Busy/Tx_over_run : transmitter pins and status
//   Rx_In/Rx_Enable        : serial input, receiver enable
//   uld_Rx_Data            : consume received character
//   Rx_Data/Rx_Empty/Rx_Frame_Err/Rx_over_run : receiver data and status
module uart_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [DIV_W-1:0]     Baud_Div,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 ld_Tx_Data,
    input  logic                 Tx_Enable,
    output logic                 Tx_Out,
    output logic                 Tx_Empty,
    output logic                 Tx_Busy,
    output logic                 Tx_over_run,
    input  logic                 Rx_In,
    input  logic                 Rx_Enable,
    input  logic                 uld_Rx_Data,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Empty,
    output logic                 Rx_Frame_Err,
    output logic                 Rx_over_run
`ifdef UART_PARITY_EN
    ,
    input  logic                 Parity_Odd,
    output logic                 Rx_Parity_Err
`endif
);

    localparam int CNT_W = $clog2(STOP_BITS * OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] OS_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] SMP_LO    = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SMP_MID   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SMP_HI    = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic tick;

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk      (Clock),
        .rst      (Reset),
        .baud_div (Baud_Div),
        .tick     (tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    uart_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_hold_q, tx_hold_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_empty_q, tx_empty_d;
    logic                 tx_busy_q, tx_busy_d;
    logic                 tx_ovr_q, tx_ovr_d;
    logic                 tx_out_q, tx_out_d;
    logic                 tx_start;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_hold_d  = tx_hold_q;
        tx_shift_d = tx_shift_q;
        tx_empty_d = tx_empty_q;
        tx_busy_d  = tx_busy_q;
        tx_ovr_d   = tx_ovr_q;
        tx_out_d   = tx_out_q;
        tx_start   = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        if (tick) begin
            case (tx_state_q)
                ST_IDLE: begin
                    tx_start = Tx_Enable && !tx_empty_q;
                end
                ST_START: begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == OS_LAST) begin
                        tx_state_d = ST_DATA;
                        tx_cnt_d   = '0;
                        tx_bit_d   = '0;
                        tx_out_d   = tx_shift_q[0];
                    end
                end
                ST_DATA: begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == OS_LAST) begin
                        tx_cnt_d = '0;
                        if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_state_d = ST_PARITY;
                            tx_out_d   = tx_par_q;
`else
                            tx_state_d = ST_STOP;
                            tx_out_d   = 1'b1;
`endif
                        end else begin
                            tx_bit_d   = tx_bit_q + 1'b1;
                            tx_shift_d = tx_shift_q >> 1;
                            tx_out_d   = tx_shift_q[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == OS_LAST) begin
                        tx_state_d = ST_STOP;
                        tx_cnt_d   = '0;
                        tx_out_d   = 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (tx_cnt_q == STOP_LAST) begin
                        // A character loaded during the frame starts straight
                        // away, so streaming has no idle bit between frames.
                        if (Tx_Enable && !tx_empty_q) begin
                            tx_start = 1'b1;
                        end else begin
                            tx_state_d = ST_IDLE;
                            tx_cnt_d   = '0;
                            tx_busy_d  = 1'b0;
                        end
                    end
                end
                default: begin
                    tx_state_d = ST_IDLE;
                end
            endcase
        end
        if (tx_start) begin
            tx_state_d = ST_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_hold_q;
            tx_empty_d = 1'b1;
            tx_busy_d  = 1'b1;
            tx_out_d   = 1'b0;
`ifdef UART_PARITY_EN
            tx_par_d   = (^tx_hold_q) ^ Parity_Odd;
`endif
        end
        // Evaluated against the post-transfer empty flag so a load in the
        // same cycle as a frame start is accepted.
        if (ld_Tx_Data) begin
            if (tx_empty_d) begin
                tx_hold_d  = Tx_Data;
                tx_empty_d = 1'b0;
                tx_ovr_d   = 1'b0;
            end else begin
                tx_ovr_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_empty_q <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_ovr_q   <= 1'b0;
            tx_out_q   <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_empty_q <= tx_empty_d;
            tx_busy_q  <= tx_busy_d;
            tx_ovr_q   <= tx_ovr_d;
            tx_out_q   <= tx_out_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        tx_hold_q  <= tx_hold_d;
        tx_shift_q <= tx_shift_d;
    end

    assign Tx_Out      = tx_out_q;
    assign Tx_Empty    = tx_empty_q;
    assign Tx_Busy     = tx_busy_q;
    assign Tx_over_run = tx_ovr_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    uart_state_e          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
    logic [1:0]           rx_smp_q, rx_smp_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_empty_q, rx_empty_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_wait_q, rx_wait_d;
    logic                 rx_sample, rx_mid, rx_end;
`ifdef UART_PARITY_EN
    logic                 rx_perr_q, rx_perr_d;
`endif

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_smp_d   = rx_smp_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_empty_d = rx_empty_q;
        rx_ferr_d  = rx_ferr_q;
        rx_ovr_d   = rx_ovr_q;
        rx_wait_d  = rx_wait_q;
`ifdef UART_PARITY_EN
        rx_perr_d  = rx_perr_q;
`endif
        // The third sample is the live bit; the first two were stored on
        // the preceding ticks.
        rx_sample = maj3(rx_smp_q[0], rx_smp_q[1], rx_s);
        rx_mid    = (rx_cnt_q == SMP_HI);
        rx_end    = (rx_cnt_q == OS_LAST);

        if (uld_Rx_Data) begin
            rx_empty_d = 1'b1;
            rx_ovr_d   = 1'b0;
        end

        if (!Rx_Enable) begin
            rx_state_d = ST_IDLE;
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_wait_d  = 1'b0;
        end else if (tick) begin
            if (rx_state_q != ST_IDLE) begin
                rx_cnt_d = rx_end ? '0 : rx_cnt_q + 1'b1;
                if (rx_cnt_q == SMP_LO)  rx_smp_d[0] = rx_s;
                if (rx_cnt_q == SMP_MID) rx_smp_d[1] = rx_s;
            end
            case (rx_state_q)
                ST_IDLE: begin
                    // The detecting tick is tick 0 of the start bit.
                    if (!rx_s) begin
                        rx_state_d = ST_START;
                        rx_cnt_d   = CNT_ONE;
                        rx_bit_d   = '0;
                    end
                end
                ST_START: begin
                    if (rx_mid && rx_sample) begin
                        rx_state_d = ST_IDLE;
                        rx_cnt_d   = '0;
                    end else if (rx_end) begin
                        rx_state_d = ST_DATA;
                        rx_bit_d   = '0;
                    end
                end
                ST_DATA: begin
                    if (rx_mid) begin
                        rx_shift_d = {rx_sample, rx_shift_q[DATA_BITS-1:1]};
                    end
                    if (rx_end) begin
                        if (rx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            rx_state_d = ST_PARITY;
`else
                            rx_state_d = ST_STOP;
`endif
                        end else begin
                            rx_bit_d = rx_bit_q + 1'b1;
                        end
                    end
                end
`ifdef UART_PARITY_EN
                ST_PARITY: begin
                    if (rx_mid) begin
                        rx_perr_d = (rx_sample != ((^rx_shift_q) ^ Parity_Odd));
                    end
                    if (rx_end) begin
                        rx_state_d = ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_wait_q) begin
                        // After a framing error, hold off until the line is
                        // back at mark so a break is not seen as a new start.
                        if (rx_s) begin
                            rx_state_d = ST_IDLE;
                            rx_cnt_d   = '0;
                            rx_wait_d  = 1'b0;
                        end
                    end else if (rx_mid) begin
                        if (rx_sample) begin
                            rx_data_d  = rx_shift_q;
                            rx_empty_d = 1'b0;
                            rx_ferr_d  = 1'b0;
                            if (!rx_empty_q && !uld_Rx_Data) begin
                                rx_ovr_d = 1'b1;
                            end
                            rx_state_d = ST_IDLE;
                            rx_cnt_d   = '0;
                        end else begin
                            rx_ferr_d = 1'b1;
                            rx_wait_d = 1'b1;
                        end
                    end
                end
                default: begin
                    rx_state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_smp_q   <= 2'b11;
            rx_data_q  <= '0;
            rx_empty_q <= 1'b1;
            rx_ferr_q  <= 1'b0;
            rx_ovr_q   <= 1'b0;
            rx_wait_q  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            rx_sync_q  <= {rx_sync_q[0], Rx_In};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_smp_q   <= rx_smp_d;
            rx_data_q  <= rx_data_d;
            rx_empty_q <= rx_empty_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_ovr_q   <= rx_ovr_d;
            rx_wait_q  <= rx_wait_d;
`ifdef UART_PARITY_EN
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

    always_ff @(posedge Clock) begin
        rx_shift_q <= rx_shift_d;
    end

    assign Rx_Data      = rx_data_q;
    assign Rx_Empty     = rx_empty_q;
    assign Rx_Frame_Err = rx_ferr_q;
    assign Rx_over_run  = rx_ovr_q;
`ifdef UART_PARITY_EN
    assign Rx_Parity_Err = rx_perr_q;
`endif

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed self-checking bench for uart_core.
// Baud_Div=4, OVERSAMPLE=16 -> 64 clocks per bit. Rx_In is either looped
// back from Tx_Out or driven bit-by-bit by the bench.
module tb_uart_core;

    localparam int BIT_CLK = 64;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic [7:0]  tx_data;
    logic        ld_tx, tx_en;
    logic        tx_out, tx_empty, tx_busy, tx_ovr;
    logic        rx_in, rx_en, uld_rx;
    logic [7:0]  rx_data;
    logic        rx_empty, rx_ferr, rx_ovr;
    logic        loop, rx_drv;
`ifdef UART_PARITY_EN
    logic        par_odd;
    logic        rx_perr;
`endif

    int n_cmp = 0;
    int n_err = 0;

    assign rx_in = loop ? tx_out : rx_drv;

    always #5 clk = ~clk;

    uart_core dut (
        .Clock        (clk),
        .Reset        (rst),
        .Baud_Div     (baud_div),
        .Tx_Data      (tx_data),
        .ld_Tx_Data   (ld_tx),
        .Tx_Enable    (tx_en),
        .Tx_Out       (tx_out),
        .Tx_Empty     (tx_empty),
        .Tx_Busy      (tx_busy),
        .Tx_over_run  (tx_ovr),
        .Rx_In        (rx_in),
        .Rx_Enable    (rx_en),
        .uld_Rx_Data  (uld_rx),
        .Rx_Data      (rx_data),
        .Rx_Empty     (rx_empty),
        .Rx_Frame_Err (rx_ferr),
        .Rx_over_run  (rx_ovr)
`ifdef UART_PARITY_EN
        ,
        .Parity_Odd   (par_odd),
        .Rx_Parity_Err(rx_perr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] d);
        tx_data = d;
        ld_tx   = 1'b1;
        step(1);
        ld_tx   = 1'b0;
    endtask

    task automatic unload();
        uld_rx = 1'b1;
        step(1);
        uld_rx = 1'b0;
    endtask

    task automatic wait_tx_fall(input string tag);
        int n = 0;
        while (tx_out && n < 1000) begin
            step(1);
            n++;
        end
        chk(tag, tx_out, 1'b0);
    endtask

    task automatic wait_rx(input string tag);
        int n = 0;
        while (rx_empty && n < 2000) begin
            step(1);
            n++;
        end
        chk(tag, rx_empty, 1'b0);
    endtask

    // Expected line level for bit k of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return (^d) ^ par_odd;
`endif
        return 1'b1;
    endfunction

    // Called right after the start bit edge has been observed.
    task automatic check_tx_frame(input logic [7:0] d);
        chk("tx_empty_at_start", tx_empty, 1'b1);
        chk("tx_busy_at_start", tx_busy, 1'b1);
        step(BIT_CLK / 2);
        for (int k = 0; k < NBITS; k++) begin
            chk($sformatf("tx_bit%0d", k), tx_out, exp_bit(d, k));
            if (k < NBITS - 1) step(BIT_CLK);
        end
        step(BIT_CLK / 2 + 8);
        chk("tx_busy_after", tx_busy, 1'b0);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic stopv);
`ifdef UART_PARITY_EN
        return {stopv, (^d) ^ par_odd, d, 1'b0};
`else
        return {1'b0, stopv, d, 1'b0};
`endif
    endfunction

    task automatic send_raw(input logic [10:0] bits);
        for (int i = 0; i < NBITS; i++) begin
            rx_drv = bits[i];
            step(BIT_CLK);
        end
        rx_drv = 1'b1;
        step(BIT_CLK);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        logic got1;
        rst = 1'b1; baud_div = 16'd4; tx_data = '0; ld_tx = 1'b0; tx_en = 1'b0;
        rx_en = 1'b1; uld_rx = 1'b0; loop = 1'b1; rx_drv = 1'b1;
`ifdef UART_PARITY_EN
        par_odd = 1'b0;
`endif
        step(3);
        chk("rst_tx_out", tx_out, 1'b1);
        chk("rst_tx_empty", tx_empty, 1'b1);
        chk("rst_tx_busy", tx_busy, 1'b0);
        chk("rst_tx_ovr", tx_ovr, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_empty", rx_empty, 1'b1);
        chk("rst_rx_ferr", rx_ferr, 1'b0);
        chk("rst_rx_ovr", rx_ovr, 1'b0);
        rst = 1'b0;
        step(10);

        // Single character 0xA5, looped back into the receiver.
        tx_en = 1'b1;
        load(8'hA5);
        chk("a5_tx_empty_loaded", tx_empty, 1'b0);
        wait_tx_fall("a5_start");
        check_tx_frame(8'hA5);
        wait_rx("a5_rx_ready");
        chk("a5_rx_data", rx_data, 8'hA5);
        chk("a5_rx_ferr", rx_ferr, 1'b0);
        unload();
        chk("a5_rx_empty_uld", rx_empty, 1'b1);
        step(BIT_CLK);

        // Tx holding overrun, then back-to-back 0x3C / 0xC3 loopback.
        tx_en = 1'b0;
        load(8'h3C);
        load(8'hFF);
        chk("tx_ovr_set", tx_ovr, 1'b1);
        chk("tx_empty_full", tx_empty, 1'b0);
        step(BIT_CLK);
        chk("tx_idle_disabled", tx_out, 1'b1);
        tx_en = 1'b1;
        wait_tx_fall("lb_start");
        tx_data = 8'hC3;
        ld_tx   = 1'b1;
        step(1);
        ld_tx   = 1'b0;
        n = 1;
        chk("lb_tx_ovr_clr", tx_ovr, 1'b0);
        chk("lb_tx_empty", tx_empty, 1'b0);
        got1 = 1'b0;
        while (tx_busy && n < 4000) begin
            uld_rx = 1'b0;
            if (!rx_empty && !got1) begin
                got1 = 1'b1;
                chk("lb_data1", rx_data, 8'h3C);
                chk("lb_ferr1", rx_ferr, 1'b0);
                uld_rx = 1'b1;
            end
            step(1);
            n++;
        end
        uld_rx = 1'b0;
        chk("lb_got1", got1, 1'b1);
        chk("lb_len", n, 2 * NBITS * BIT_CLK);
        wait_rx("lb_rx2");
        chk("lb_data2", rx_data, 8'hC3);
        chk("lb_ovr2", rx_ovr, 1'b0);
        chk("lb_ferr2", rx_ferr, 1'b0);
        unload();

        // Receiver driven directly from here on.
        loop = 1'b0;
        rx_drv = 1'b1;
        step(BIT_CLK);

        // Overrun: two frames, no unload.
        send_raw(frame(8'h12, 1'b1));
        send_raw(frame(8'h34, 1'b1));
        chk("ovr_data", rx_data, 8'h34);
        chk("ovr_flag", rx_ovr, 1'b1);
        chk("ovr_empty", rx_empty, 1'b0);
        unload();
        chk("ovr_uld_empty", rx_empty, 1'b1);
        chk("ovr_uld_flag", rx_ovr, 1'b0);

        // Start-bit glitch of 20 clocks.
        rx_drv = 1'b0;
        step(20);
        rx_drv = 1'b1;
        step(4 * BIT_CLK);
        chk("glitch_empty", rx_empty, 1'b1);
        chk("glitch_ferr", rx_ferr, 1'b0);
        send_raw(frame(8'h5A, 1'b1));
        chk("after_glitch_data", rx_data, 8'h5A);
        chk("after_glitch_empty", rx_empty, 1'b0);
        unload();

        // Framing error: stop bit 0.
        send_raw(frame(8'h55, 1'b0));
        step(BIT_CLK);
        chk("ferr_flag", rx_ferr, 1'b1);
        chk("ferr_empty", rx_empty, 1'b1);
        chk("ferr_data_kept", rx_data, 8'h5A);
        send_raw(frame(8'h0F, 1'b1));
        chk("ferr_clr", rx_ferr, 1'b0);
        chk("ferr_next_data", rx_data, 8'h0F);
        unload();

`ifdef UART_PARITY_EN
        // Parity: 0x07 even parity -> parity bit 1.
        loop = 1'b1;
        step(BIT_CLK);
        load(8'h07);
        wait_tx_fall("par_start");
        check_tx_frame(8'h07);
        wait_rx("par_rx");
        chk("par_ok_data", rx_data, 8'h07);
        chk("par_ok_err", rx_perr, 1'b0);
        unload();
        loop = 1'b0;
        rx_drv = 1'b1;
        step(BIT_CLK);
        send_raw({1'b1, 1'b0, 8'h07, 1'b0});
        chk("par_bad_err", rx_perr, 1'b1);
        chk("par_bad_data", rx_data, 8'h07);
        unload();
        send_raw(frame(8'h07, 1'b1));
        chk("par_clr", rx_perr, 1'b0);
        unload();
`endif

        // Reset in the middle of a transmitted frame.
        loop = 1'b1;
        load(8'h99);
        wait_tx_fall("mid_rst_start");
        step(3 * BIT_CLK);
        rst = 1'b1;
        #2;
        chk("mid_rst_tx_out", tx_out, 1'b1);
        chk("mid_rst_tx_busy", tx_busy, 1'b0);
        chk("mid_rst_tx_empty", tx_empty, 1'b1);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        step(2);
        rst = 1'b0;
        step(4 * BIT_CLK);
        chk("post_rst_tx_out", tx_out, 1'b1);
        chk("post_rst_rx_empty", rx_empty, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_core.md
# uart_core

Parametrised single-clock UART transceiver, next generation of the dual-clock `uart1`. It contains an internal programmable baud generator, an oversampling receiver with 3-sample majority voting, and a double-buffered transmitter. Data width and stop-bit count are configurable, and parity is optional. It sits between a register/bus interface and the serial pins.

## Interface
- `DATA_BITS`, 8: character width, legal range 5..9.
- `OVERSAMPLE`, 16: ticks per bit period; even, ≥ 8.
- `STOP_BITS`, 1: transmitted stop bits, 1 or 2. Rx checks only the first stop bit.
- `DIV_W`, 16: width of `Baud_Div`.
- Clock and reset: one clock, `Clock`; reset `Reset` is asynchronous and active-high.
- `Clock`  in  1  system clock.
- `Reset`  in  1  async active-high reset.
- `Baud_Div`  in  DIV_W  clocks per oversample tick; 0 is treated as 1.
- `Tx_Data`  in  DATA_BITS  character to send.
- `ld_Tx_Data`  in  1  load `Tx_Data` into the holding register.
- `Tx_Enable`  in  1  permit a new frame to start.
- `Tx_Out`  out  1  serial output; reset value 1.
- `Tx_Empty`  out  1  holding register free; reset value 1.
- `Tx_Busy`  out  1  frame in progress; reset value 0.
- `Tx_over_run`  out  1  sticky; a load was attempted while the holding register was full; reset value 0.
- `Rx_In`  in  1  asynchronous serial input.
- `Rx_Enable`  in  1  receiver enable.
- `uld_Rx_Data`  in  1  consume the received character.
- `Rx_Data`  out  DATA_BITS  last good character; reset value 0.
- `Rx_Empty`  out  1  no unread character; reset value 1.
- `Rx_Frame_Err`  out  1  last frame's stop bit was 0; reset value 0.
- `Rx_over_run`  out  1  sticky; a character arrived while unread; reset value 0.
- `Parity_Odd`  in  1  with `UART_PARITY_EN` only: 1 = odd parity, 0 = even.
- `Rx_Parity_Err`  out  1  with `UART_PARITY_EN` only; reset value 0.

## Operation
- **Baud generator**
  - Counter runs 0..`Baud_Div`−1.
  - `Tick` is a one-clock pulse when the counter wraps.
  - A change to `Baud_Div` takes effect at the next wrap.
  - One bit period is `OVERSAMPLE` ticks.
- **Tx holding register**
  - `ld_Tx_Data` with `Tx_Empty`=1: capture `Tx_Data`, `Tx_Empty`←0, `Tx_over_run`←0.
  - `ld_Tx_Data` with `Tx_Empty`=0: data is dropped and `Tx_over_run`←1.
- **Tx FSM**: states IDLE → START → DATA → [PARITY] → STOP → IDLE.
  - IDLE→START on a `Tick` with `Tx_Enable`=1 and `Tx_Empty`=0.
  - On that transition: copy holding to shift register, `Tx_Empty`←1, `Tx_Busy`←1.
  - Each state lasts `OVERSAMPLE` ticks.
  - DATA sends LSB first, `DATA_BITS` bits.
  - STOP lasts `STOP_BITS` bit periods.
  - In IDLE and STOP, `Tx_Out`=1.
  - Dropping `Tx_Enable` does not abort a frame in progress; it only blocks the next start.
  - A load during a frame refills the holding register, giving back-to-back frames with no idle bit.
- **Rx synchroniser**: two flops, reset to 1. The FSM uses only the synchronised bit.
- **Rx FSM**: states IDLE → START → DATA → [PARITY] → STOP → IDLE. Counters advance on `Tick` only.
  - IDLE→START on a `Tick` that sees a synchronised 0.
  - Samples are taken at ticks `OVERSAMPLE/2`−1, `OVERSAMPLE/2` and `OVERSAMPLE/2`+1 of each bit; the bit value is the majority of the three.
  - Start majority = 1: treat as a glitch and return to IDLE with no flags changed.
  - STOP majority = 0: `Rx_Frame_Err`←1, `Rx_Data` and `Rx_Empty` unchanged. Return to IDLE only after the line returns to 1.
  - STOP majority = 1:
    - `Rx_Data`←shift register, `Rx_Empty`←0, `Rx_Frame_Err`←0.
    - `Rx_over_run`←1 if `Rx_Empty` was 0.
  - `Rx_Enable`=0: FSM forced to IDLE every cycle; outputs hold their values.
- **uld_Rx_Data**: `Rx_Empty`←1, `Rx_over_run`←0.
- **Simultaneous events**
  - `uld_Rx_Data` in the same cycle as a good stop bit: the new character wins (`Rx_Empty`=0) and no overrun is flagged.
  - `ld_Tx_Data` in the same cycle as IDLE→START: the transfer happens first, then the load is accepted.
- **Reset mid-frame**: both FSMs go to IDLE immediately; all outputs take their reset values.

## Timing
- All outputs are registered.
- Tx latency: `Tx_Out` falls on the first `Tick` after `Tx_Empty`=0 and `Tx_Enable`=1.
- Tx frame length: (1 + `DATA_BITS` + P + `STOP_BITS`) × `OVERSAMPLE` × `Baud_Div` clocks, where P = 1 with parity, 0 without.
- Rx latency: `Rx_Empty` falls `OVERSAMPLE/2`+1 ticks + 1 clock after the start of the stop bit on `Rx_In`, plus 2 clocks of synchroniser delay.
- Minimum time between loads for continuous streaming: one frame time.

## Configuration
- `UART_PARITY_EN` defined:
  - PARITY state is present in both FSMs.
  - Tx sends a parity bit computed over the data bits per `Parity_Odd`.
  - Rx checks it: on mismatch, `Rx_Parity_Err`←1, but the character is still delivered. `Rx_Parity_Err` clears on the next frame with correct parity.
- `UART_PARITY_EN` undefined: `Parity_Odd`, `Rx_Parity_Err` and the PARITY states do not exist.

## Structure
- Package `uart_pkg`: Tx/Rx state enum typedef and the majority-vote function.
- Sub-module `uart_baud_gen`: divider counter and tick output, parameter `DIV_W`.
- Tx and Rx are separate always blocks in `uart_core`.

## Test plan
All scenarios use `Baud_Div`=4, `OVERSAMPLE`=16, `DATA_BITS`=8, `STOP_BITS`=1, giving 64 clocks per bit.
- **Transmit one character**: load 0xA5 → `Tx_Out` sequence 0,1,0,1,0,0,1,0,1,1, each bit 64 clocks; `Tx_Empty` returns to 1 at start-bit entry.
- **Loopback**: `Tx_Out`→`Rx_In` with 0x3C then 0xC3 loaded back-to-back → `Rx_Data`=0x3C, uld, then `Rx_Data`=0xC3, no errors, 1280 clocks total.
- **Start glitch**: drive `Rx_In` low for 20 clocks → no character, `Rx_Empty` stays 1, FSM back in IDLE.
- **Framing error**: frame 0x55 with stop bit 0 → `Rx_Frame_Err`=1, `Rx_Empty`=1, `Rx_Data` unchanged.
- **Rx overrun**: two frames received with no uld → `Rx_Data`=second character, `Rx_over_run`=1; uld → both clear.
- **Parity** (with `UART_PARITY_EN`, `Parity_Odd`=0): send 0x07 → parity bit 1; corrupt it → `Rx_Parity_Err`=1, `Rx_Data`=0x07.
